// File: rtl/xor_cipher_ctrl.sv
// Purpose : sequencing controller for an XOR cipher datapath: key load, message
//           load, encrypt trigger, wait for encryptor, wait for serializer, done.
// Latency : iStart to oDone = 1 + KEY_SIZE + MSG_SIZE + 1 + enc wait + send wait + 1
//           cycles when ena stays high and serial data has no gaps.
// Backpr. : ena=0 freezes the controller (state, counters, error) and gates all
//           strobes low; iSerial_valid gaps simply stretch the load states.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        global enable / freeze
//   iStart                     begin a transaction (IDLE only)
//   iSerial_valid              one serial key/message bit present this cycle
//   iAbort                     return to IDLE from any busy state (highest priority)
//   iEncrypt_done              encryptor finished (WAIT_ENC only)
//   iSerial_end                serializer emitted its last bit (SEND only)
//   oLoad_key, oLoad_msg       deserializer load strobes
//   oCan_encrypt               one-cycle encrypt trigger
//   oReady / oBusy             IDLE / not IDLE
//   oDone                      one-cycle completion pulse
//   oError                     sticky timeout flag, cleared by the next iStart
//   oState                     raw state encoding
module xor_cipher_ctrl #(
  parameter int KEY_SIZE = 32,
  parameter int MSG_SIZE = 512,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       iStart,
  input  logic       iSerial_valid,
  input  logic       iAbort,
  input  logic       iEncrypt_done,
  input  logic       iSerial_end,
  output logic       oLoad_key,
  output logic       oLoad_msg,
  output logic       oCan_encrypt,
  output logic       oReady,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  localparam int BW = $clog2(MSG_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [BW-1:0] KEY_LIM = BW'(KEY_SIZE);
  localparam logic [BW-1:0] MSG_LIM = BW'(MSG_SIZE);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_LOAD_MSG = 3'd2,
    S_ENCRYPT  = 3'd3,
    S_WAIT_ENC = 3'd4,
    S_SEND     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic            err_q;

  logic [BW-1:0]   bit_cnt_d;
  logic [TW-1:0]   to_cnt_d;
  logic            to_hit;

  // Incremented values shared by both load states and both wait states.
  // The timeout counter saturates so it can never wrap past TIMEOUT.
  assign bit_cnt_d = bit_cnt_q + 1'b1;
  assign to_cnt_d  = (to_cnt_q == TO_LIM) ? to_cnt_q : to_cnt_q + 1'b1;
  assign to_hit    = (to_cnt_d == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else if (ena) begin
      // Abort wins over every other transition, including a completion or
      // timeout in the same cycle; the sticky error is left alone.
      if (iAbort && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        to_cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (iStart) begin
              state_q   <= S_LOAD_KEY;
              bit_cnt_q <= '0;
              to_cnt_q  <= '0;
              err_q     <= 1'b0;
            end
          end
          S_LOAD_KEY: begin
            if (iSerial_valid) begin
              if (bit_cnt_d == KEY_LIM) begin
                state_q   <= S_LOAD_MSG;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_LOAD_MSG: begin
            if (iSerial_valid) begin
              if (bit_cnt_d == MSG_LIM) begin
                state_q   <= S_ENCRYPT;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_ENCRYPT: begin
            state_q  <= S_WAIT_ENC;
            to_cnt_q <= '0;
          end
          S_WAIT_ENC: begin
            if (iEncrypt_done) begin
              state_q  <= S_SEND;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_d;
              if (to_hit) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
              end
            end
          end
          S_SEND: begin
            if (iSerial_end) begin
              state_q <= S_DONE;
            end else begin
              to_cnt_q <= to_cnt_d;
              if (to_hit) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          // Unused code 7 recovers to IDLE.
          default: begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  // Strobes are qualified by ena so a frozen controller drives nothing.
  assign oLoad_key    = (state_q == S_LOAD_KEY) && ena;
  assign oLoad_msg    = (state_q == S_LOAD_MSG) && ena;
  assign oCan_encrypt = (state_q == S_ENCRYPT)  && ena;
  assign oDone        = (state_q == S_DONE)     && ena;
  assign oReady       = (state_q == S_IDLE);
  assign oBusy        = (state_q != S_IDLE);
  assign oError       = err_q;
  assign oState       = state_q;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Purpose : self-checking bench for xor_cipher_ctrl; each transaction is planned
//           as a per-cycle list of inputs plus the state/error it must show.
// Latency : one plan entry per clock; outputs checked at negedge + 1.
// Backpr. : ena=0 cycles are part of the plan and expect all strobes low.
module tb_xor_cipher_ctrl;

  localparam int KEY = 32;
  localparam int MSG = 512;
  localparam int TO  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       iStart = 1'b0;
  logic       iSerial_valid = 1'b0;
  logic       iAbort = 1'b0;
  logic       iEncrypt_done = 1'b0;
  logic       iSerial_end = 1'b0;
  logic       oLoad_key, oLoad_msg, oCan_encrypt, oReady, oBusy, oDone, oError;
  logic [2:0] oState;

  always #5 clk = ~clk;

  xor_cipher_ctrl #(.KEY_SIZE(KEY), .MSG_SIZE(MSG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .iStart(iStart),
    .iSerial_valid(iSerial_valid), .iAbort(iAbort),
    .iEncrypt_done(iEncrypt_done), .iSerial_end(iSerial_end),
    .oLoad_key(oLoad_key), .oLoad_msg(oLoad_msg), .oCan_encrypt(oCan_encrypt),
    .oReady(oReady), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oState(oState)
  );

  typedef struct {
    bit       ena, start, valid, abort, done, send_end;
    bit [2:0] st;
    bit       err;
  } cyc_t;

  cyc_t tl[$];

  int  errs = 0;
  int  checks = 0;
  bit  m_err = 1'b0;
  int  gap_mode, frz_pct, abort_ph, abort_pos, frz5_pos;
  int  cnt_st[8];
  int  cnt_lk, cnt_lm, cnt_enc, cnt_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {oState, oLoad_key, oLoad_msg, oCan_encrypt, oReady, oBusy, oDone, oError};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit ab(input int ph, input int pos);
    return (abort_ph == ph) && (abort_pos == pos);
  endfunction

  task automatic quiet();
    ena = 1'b1; iStart = 1'b0; iSerial_valid = 1'b0;
    iAbort = 1'b0; iEncrypt_done = 1'b0; iSerial_end = 1'b0;
  endtask

  task automatic knobs(input int g, input int f, input int aph, input int apos, input int f5);
    gap_mode = g; frz_pct = f; abort_ph = aph; abort_pos = apos; frz5_pos = f5;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 8; i++) cnt_st[i] = 0;
    cnt_lk = 0; cnt_lm = 0; cnt_enc = 0; cnt_done = 0;
  endtask

  task automatic push(input bit en, input bit start, input bit valid, input bit abort,
                      input bit done, input bit send_end, input bit [2:0] st);
    cyc_t c;
    c.ena = en; c.start = start; c.valid = valid; c.abort = abort;
    c.done = done; c.send_end = send_end; c.st = st; c.err = m_err;
    tl.push_back(c);
  endtask

  // A frozen cycle: every input is noise except the requested valid level.
  task automatic push_frz(input bit [2:0] st, input bit valid);
    push(1'b0, rb(), valid, rb(), rb(), rb(), st);
  endtask

  // One enabled cycle in state st; inputs that st must ignore are randomized.
  task automatic emit(input bit [2:0] st, input bit start, input bit valid,
                      input bit abort, input bit done, input bit send_end);
    bit s, v, a, d, e;
    s = start; v = valid; a = abort; d = done; e = send_end;
    if ($urandom_range(0, 99) < frz_pct)
      repeat ($urandom_range(1, 3)) push_frz(st, rb());
    if (st != 3'd0) s = rb();
    else            a = rb();
    if (st != 3'd1 && st != 3'd2) v = rb();
    if (st != 3'd4) d = rb();
    if (st != 3'd5) e = rb();
    push(1'b1, s, v, a, d, e, st);
  endtask

  // Plan one transaction. w/s: cycles without completion in WAIT_ENC/SEND;
  // to_ph: 4 or 5 lets that wait state time out; cut_send stops inside SEND.
  task automatic build_txn(input int w, input int s, input int to_ph, input bit cut_send);
    int cnt, pos, lim, n;
    bit v, tmo;
    repeat ($urandom_range(0, 2)) emit(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    emit(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_err = 1'b0;
    for (int ph = 1; ph <= 2; ph++) begin
      lim = (ph == 1) ? KEY : MSG;
      cnt = 0; pos = 0;
      while (cnt < lim) begin
        if (ab(ph, pos)) begin emit(3'(ph), 1'b0, rb(), 1'b1, 1'b0, 1'b0); return; end
        if (ph == 2 && pos == frz5_pos) repeat (5) push_frz(3'(ph), 1'b1);
        v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? ~pos[0] : rb();
        emit(3'(ph), 1'b0, v, 1'b0, 1'b0, 1'b0);
        if (v) cnt++;
        pos++;
      end
    end
    if (ab(3, 0)) begin emit(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); return; end
    emit(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int ph = 4; ph <= 5; ph++) begin
      tmo = (to_ph == ph);
      n = tmo ? TO : ((ph == 4) ? w : s);
      for (int i = 0; i < n; i++) begin
        if (ab(ph, i)) begin emit(3'(ph), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); return; end
        emit(3'(ph), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (tmo) begin m_err = 1'b1; return; end
      if (cut_send && ph == 5) return;
      if (ab(ph, n)) begin emit(3'(ph), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); return; end
      emit(3'(ph), 1'b0, 1'b0, 1'b0, ph == 4, ph == 5);
    end
    if (ab(6, 0)) begin emit(3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); return; end
    emit(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_tl();
    cyc_t c;
    logic [9:0] e;
    while (tl.size() > 0) begin
      c = tl.pop_front();
      @(negedge clk);
      ena = c.ena; iStart = c.start; iSerial_valid = c.valid; iAbort = c.abort;
      iEncrypt_done = c.done; iSerial_end = c.send_end;
      #1;
      e = {c.st, c.ena && (c.st == 3'd1), c.ena && (c.st == 3'd2),
           c.ena && (c.st == 3'd3), c.st == 3'd0, c.st != 3'd0,
           c.ena && (c.st == 3'd6), c.err};
      chk("outs", 32'(outs()), 32'(e));
      cnt_st[oState]++;
      if (oLoad_key)    cnt_lk++;
      if (oLoad_msg)    cnt_lm++;
      if (oCan_encrypt) cnt_enc++;
      if (oDone)        cnt_done++;
    end
    @(posedge clk);
    #1;
    quiet();
  endtask

  initial begin
    quiet();
    knobs(0, 0, 0, 0, -1);
    // Reset held across edges with iStart high: nothing may move.
    rst_n = 1'b0;
    iStart = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'h008);
    @(negedge clk);
    iStart = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_release", 32'(outs()), 32'h008);

    // Nominal, gapless: 32 key strobes, 512 message strobes, one trigger, one done.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(2, 10, 0, 1'b0); run_tl();
    chk("nom_load_key", cnt_lk, KEY);
    chk("nom_load_msg", cnt_lm, MSG);
    chk("nom_encrypt", cnt_enc, 1);
    chk("nom_done", cnt_done, 1);
    chk("nom_ready", 32'(oReady), 1);

    // Valid toggling 1/0: key phase spans 63 cycles.
    clear_mon(); knobs(1, 0, 0, 0, -1);
    build_txn(0, 0, 0, 1'b0); run_tl();
    chk("gap_key_cycles", cnt_st[1], 2 * KEY - 1);

    // Five frozen cycles with valid high in the middle of LOAD_MSG.
    clear_mon(); knobs(0, 0, 0, 0, 100);
    build_txn(1, 1, 0, 1'b0); run_tl();
    chk("frz_load_msg", cnt_lm, MSG);
    chk("frz_msg_cycles", cnt_st[2], MSG + 5);

    // Encryptor never answers: full timeout, sticky error.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(0, 0, 4, 1'b0); run_tl();
    chk("to_wait_cycles", cnt_st[4], TO);
    chk("to_error", 32'(oError), 1);

    // Next start clears the error; done on the last legal wait cycle still wins.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(TO - 1, 2, 0, 1'b0); run_tl();
    chk("late_done_send", cnt_st[5], 3);
    chk("late_done_err", 32'(oError), 0);

    // Serializer timeout.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(1, 0, 5, 1'b0); run_tl();
    chk("to_send_cycles", cnt_st[5], TO);
    chk("to_send_err", 32'(oError), 1);

    // Abort together with iEncrypt_done: back to IDLE, SEND never entered.
    clear_mon(); knobs(0, 0, 4, 2, -1);
    build_txn(5, 3, 0, 1'b0); run_tl();
    chk("abort_no_send", cnt_st[5], 0);
    chk("abort_err", 32'(oError), 0);

    // Abort on the cycle the timeout would fire: no error.
    clear_mon(); knobs(0, 0, 4, TO - 1, -1);
    build_txn(0, 0, 4, 1'b0); run_tl();
    chk("abort_vs_timeout", 32'(oError), 0);

    // Randomized transactions: gaps, freezes, aborts, noise on ignored inputs.
    for (int t = 0; t < 8; t++) begin
      clear_mon();
      knobs(2, 8, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
            int'($urandom_range(0, 40)), -1);
      build_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                (t == 5) ? 5 : 0, 1'b0);
      run_tl();
      chk("rnd_idle_end", 32'(oState), 0);
    end

    // Asynchronous reset in the middle of SEND.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(3, 5, 0, 1'b1); run_tl();
    chk("pre_rst_send", 32'(oState), 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_send", 32'(outs()), 32'h008);
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset also clears a sticky error.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(0, 0, 4, 1'b0); run_tl();
    chk("err_before_rst", 32'(oError), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_err", 32'(outs()), 32'h008);
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Clean transaction after reset.
    clear_mon(); knobs(0, 0, 0, 0, -1);
    build_txn(0, 0, 0, 1'b0); run_tl();
    chk("recover_done", cnt_done, 1);
    chk("recover_ready", 32'(oReady), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
